// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory-side definitions: read-return FSM states and bus widths.
package mem_arbiter_pkg;

  localparam int ADR_W_DEFAULT = 20;
  localparam int DATA_W        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_LS = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_prio_arb.sv
// Fixed load/store priority with a starvation override in favour of instruction fetch.
module starve_prio_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             if_req,
  input  logic             ls_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             if_gnt,
  output logic             ls_gnt
);

  logic if_wins;

  // Fetch wins when alone, or when it has lost the maximum allowed number of rounds.
  assign if_wins = if_req & (~ls_req | (starve_cnt == CNT_W'(STARVE_LIMIT)));
  assign if_gnt  = if_wins;
  assign ls_gnt  = ls_req & ~if_wins;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with read-return FSM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADR_W        = ADR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADR_W-1:0]  if_adr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADR_W-1:0]  ls_adr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_req_g;
  logic             ls_req_g;

  // Requests are masked during reset so no grant or memory strobe can leak out.
  assign if_req_g = if_req & ~reset;
  assign ls_req_g = ls_req & ~reset;

  starve_prio_arb #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_prio (
    .if_req    (if_req_g),
    .ls_req    (ls_req_g),
    .starve_cnt(starve_cnt),
    .if_gnt    (if_gnt),
    .ls_gnt    (ls_gnt)
  );

  always_comb begin
    mem_adr   = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (if_gnt) begin
      mem_adr   = if_adr;
      mem_wdata = ls_wdata;
      mem_re    = 1'b1;
    end else if (ls_gnt) begin
      mem_adr   = ls_adr;
      mem_wdata = ls_wdata;
      mem_we    = ls_we;
      mem_re    = ~ls_we;
    end
  end

  // Stage boundary: grant cycle -> read-return cycle (memory latency is one cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      if (if_gnt)
        state <= RD_IF;
      else if (ls_gnt && !ls_we)
        state <= RD_LS;
      else
        state <= IDLE;

      if (if_req && !if_gnt)
        starve_cnt <= (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt
                                                          : starve_cnt + CNT_W'(1);
      else
        starve_cnt <= '0;
    end
  end

  // A read whose return cycle coincides with reset is dropped.
  assign if_rvalid = (state == RD_IF) & ~reset;
  assign ls_rvalid = (state == RD_LS) & ~reset;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule
